// File: rtl/sram_arbiter_if.sv
// SRAM-like request/response bus used by both masters and by the shared slave port.
interface sram_arbiter_if;
   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [3:0]  wstrb;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;

   modport master (
      output req, wr, size, wstrb, addr, wdata,
      input  addr_ok, data_ok, rdata
   );

   modport slave (
      input  req, wr, size, wstrb, addr, wdata,
      output addr_ok, data_ok, rdata
   );
endinterface

// File: rtl/sram_arbiter.sv
// Two-master SRAM-like bus arbiter; an owner FIFO routes in-order returns to the right master.
// Define SRAM_ARB_RR_EN for round-robin arbitration; default is fixed data-over-inst priority.
module sram_arbiter #(
   parameter int unsigned OUTSTD_DEPTH = 4
) (
   input  logic           clk,
   input  logic           resetn,
   sram_arbiter_if.slave  inst,
   sram_arbiter_if.slave  data,
   sram_arbiter_if.master mem
);
   localparam int unsigned PtrW = $clog2(OUTSTD_DEPTH);
   localparam int unsigned CntW = $clog2(OUTSTD_DEPTH) + 1;
   localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
   localparam logic [CntW-1:0] CntOne  = CntW'(1);
   localparam logic [CntW-1:0] CntFull = CntW'(OUTSTD_DEPTH);

   typedef enum logic [1:0] {StIdle, StGrantI, StGrantD} state_e;

   state_e                  state_q;
   logic [OUTSTD_DEPTH-1:0] owner_q;
   logic [PtrW-1:0]         wptr_q;
   logic [PtrW-1:0]         rptr_q;
   logic [CntW-1:0]         count_q;
`ifdef SRAM_ARB_RR_EN
   logic                    last_q;
`endif

   logic full;
   logic empty;
   logic pop;
   logic space;
   logic head;
   logic granted;
   logic sel_data;
   logic accept;

   assign full     = (count_q == CntFull);
   assign empty    = (count_q == '0);
   assign pop      = mem.data_ok && !empty;
   // A same-cycle return frees a slot, so it counts as room for a new transaction.
   assign space    = !full || pop;
   assign head     = owner_q[rptr_q];
   assign granted  = (state_q != StIdle);
   assign sel_data = (state_q == StGrantD);

   assign mem.req   = granted && space;
   assign mem.wr    = sel_data ? data.wr    : inst.wr;
   assign mem.size  = sel_data ? data.size  : inst.size;
   assign mem.wstrb = sel_data ? data.wstrb : inst.wstrb;
   assign mem.addr  = sel_data ? data.addr  : inst.addr;
   assign mem.wdata = sel_data ? data.wdata : inst.wdata;
   assign accept    = mem.req && mem.addr_ok;

   assign inst.addr_ok = accept && !sel_data;
   assign data.addr_ok = accept && sel_data;
   assign inst.data_ok = pop && !head;
   assign data.data_ok = pop && head;
   assign inst.rdata   = mem.rdata;
   assign data.rdata   = mem.rdata;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= StIdle;
         owner_q <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
`ifdef SRAM_ARB_RR_EN
         last_q  <= 1'b0;
`endif
      end else begin
         case (state_q)
            StIdle: begin
               if (space) begin
`ifdef SRAM_ARB_RR_EN
                  if (data.req && (!inst.req || !last_q)) state_q <= StGrantD;
`else
                  if (data.req) state_q <= StGrantD;
`endif
                  else if (inst.req) state_q <= StGrantI;
               end
            end
            StGrantI, StGrantD: begin
               if (accept) state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase

         if (accept) begin
            owner_q[wptr_q] <= sel_data;
            wptr_q          <= wptr_q + PtrOne;
`ifdef SRAM_ARB_RR_EN
            last_q          <= sel_data;
`endif
         end
         if (pop) rptr_q <= rptr_q + PtrOne;

         if (accept && !pop) count_q <= count_q + CntOne;
         else if (!accept && pop) count_q <= count_q - CntOne;
      end
   end
endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model (grant owner + owner queue).
module tb_sram_arbiter;
   localparam int unsigned Depth = 4;

   logic clk;
   logic resetn;
   int   total;
   int   bad;

   sram_arbiter_if inst_bus ();
   sram_arbiter_if data_bus ();
   sram_arbiter_if mem_bus ();

   sram_arbiter #(
      .OUTSTD_DEPTH(Depth)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .inst   (inst_bus),
      .data   (data_bus),
      .mem    (mem_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle_inputs();
      inst_bus.req = 1'b0; inst_bus.wr = 1'b0; inst_bus.size = 2'd0; inst_bus.wstrb = 4'd0;
      inst_bus.addr = 32'd0; inst_bus.wdata = 32'd0;
      data_bus.req = 1'b0; data_bus.wr = 1'b0; data_bus.size = 2'd0; data_bus.wstrb = 4'd0;
      data_bus.addr = 32'd0; data_bus.wdata = 32'd0;
      mem_bus.addr_ok = 1'b0; mem_bus.data_ok = 1'b0; mem_bus.rdata = 32'd0;
   endtask

   // Leaves the caller at a falling edge, reset released, inputs idle.
   task automatic do_reset();
      @(negedge clk);
      idle_inputs();
      resetn = 1'b0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic test_reset();
      logic [4:0] got;
      @(negedge clk);
      resetn = 1'b0;
      inst_bus.req = 1'b1; data_bus.req = 1'b1;
      mem_bus.addr_ok = 1'b1; mem_bus.data_ok = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         got = {mem_bus.req, inst_bus.addr_ok, data_bus.addr_ok, inst_bus.data_ok,
                data_bus.data_ok};
         total++;
         if (got !== 5'b0) begin
            bad++;
            $display("FAIL reset_outputs cycle=%0d got=%b want=00000", i, got);
         end
      end
      idle_inputs();
      resetn = 1'b1;
   endtask

   task automatic test_single_inst();
      do_reset();
      inst_bus.req = 1'b1; inst_bus.wr = 1'b0; inst_bus.size = 2'd2; inst_bus.addr = 32'h1c00_0000;
      #1;
      total++;
      if (mem_bus.req !== 1'b0) begin
         bad++; $display("FAIL single_req_latency got=%b want=0", mem_bus.req);
      end
      @(negedge clk);
      mem_bus.addr_ok = 1'b1;
      #1;
      total++;
      if ({mem_bus.req, mem_bus.addr} !== {1'b1, 32'h1c00_0000}) begin
         bad++; $display("FAIL single_grant got=%b/%h want=1/1c000000", mem_bus.req, mem_bus.addr);
      end
      total++;
      if ({inst_bus.addr_ok, data_bus.addr_ok} !== 2'b10) begin
         bad++;
         $display("FAIL single_addr_ok got=%b%b want=10", inst_bus.addr_ok, data_bus.addr_ok);
      end
      @(negedge clk);
      inst_bus.req = 1'b0; mem_bus.addr_ok = 1'b0;
      #1;
      total++;
      if (mem_bus.req !== 1'b0) begin
         bad++; $display("FAIL single_idle_after_accept got=%b want=0", mem_bus.req);
      end
      @(negedge clk);
      mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'h0280_0c0c;
      #1;
      total++;
      if ({inst_bus.data_ok, data_bus.data_ok, inst_bus.rdata} !== {2'b10, 32'h0280_0c0c}) begin
         bad++;
         $display("FAIL single_return got=%b%b/%h want=10/02800c0c", inst_bus.data_ok,
                  data_bus.data_ok, inst_bus.rdata);
      end
      @(negedge clk);
      mem_bus.data_ok = 1'b0;
      #1;
      total++;
      if ({inst_bus.data_ok, data_bus.data_ok} !== 2'b00) begin
         bad++;
         $display("FAIL single_pulse_end got=%b%b want=00", inst_bus.data_ok, data_bus.data_ok);
      end
   endtask

   task automatic test_both();
      do_reset();
      inst_bus.req = 1'b1; inst_bus.wr = 1'b0; inst_bus.addr = 32'h1000_0040;
      data_bus.req = 1'b1; data_bus.wr = 1'b1; data_bus.addr = 32'h8000_0100;
      data_bus.wdata = 32'hdead_beef; data_bus.wstrb = 4'hf; data_bus.size = 2'd2;
      @(negedge clk);
      mem_bus.addr_ok = 1'b1;
      #1;
      total++;
      if ({mem_bus.req, mem_bus.wr, mem_bus.addr, mem_bus.wdata} !==
          {1'b1, 1'b1, 32'h8000_0100, 32'hdead_beef}) begin
         bad++;
         $display("FAIL both_first_data got=%b%b/%h/%h want=11/80000100/deadbeef", mem_bus.req,
                  mem_bus.wr, mem_bus.addr, mem_bus.wdata);
      end
      total++;
      if ({inst_bus.addr_ok, data_bus.addr_ok} !== 2'b01) begin
         bad++;
         $display("FAIL both_addr_ok_d got=%b%b want=01", inst_bus.addr_ok, data_bus.addr_ok);
      end
      @(negedge clk);
      data_bus.req = 1'b0; mem_bus.addr_ok = 1'b0;
      #1;
      total++;
      if ({mem_bus.req, inst_bus.addr_ok} !== 2'b00) begin
         bad++; $display("FAIL both_idle_gap got=%b%b want=00", mem_bus.req, inst_bus.addr_ok);
      end
      @(negedge clk);
      mem_bus.addr_ok = 1'b1; mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'haaaa_5555;
      #1;
      total++;
      if ({mem_bus.req, mem_bus.wr, mem_bus.addr} !== {1'b1, 1'b0, 32'h1000_0040}) begin
         bad++;
         $display("FAIL both_second_inst got=%b%b/%h want=10/10000040", mem_bus.req, mem_bus.wr,
                  mem_bus.addr);
      end
      total++;
      if ({inst_bus.addr_ok, data_bus.addr_ok} !== 2'b10) begin
         bad++;
         $display("FAIL both_addr_ok_i got=%b%b want=10", inst_bus.addr_ok, data_bus.addr_ok);
      end
      total++;
      if ({inst_bus.data_ok, data_bus.data_ok, data_bus.rdata} !== {2'b01, 32'haaaa_5555}) begin
         bad++;
         $display("FAIL both_ret_data got=%b%b/%h want=01/aaaa5555", inst_bus.data_ok,
                  data_bus.data_ok, data_bus.rdata);
      end
      @(negedge clk);
      inst_bus.req = 1'b0; mem_bus.addr_ok = 1'b0; mem_bus.rdata = 32'h1234_5678;
      #1;
      total++;
      if ({inst_bus.data_ok, data_bus.data_ok, inst_bus.rdata} !== {2'b10, 32'h1234_5678}) begin
         bad++;
         $display("FAIL both_ret_inst got=%b%b/%h want=10/12345678", inst_bus.data_ok,
                  data_bus.data_ok, inst_bus.rdata);
      end
      @(negedge clk);
      #1;
      total++;
      if ({inst_bus.data_ok, data_bus.data_ok} !== 2'b00) begin
         bad++;
         $display("FAIL both_spurious got=%b%b want=00", inst_bus.data_ok, data_bus.data_ok);
      end
      @(negedge clk);
      mem_bus.data_ok = 1'b0;
   endtask

   task automatic test_arb();
      logic [3:0] seq;
      logic [3:0] want;
      int         g;
      seq = 4'b0;
      g   = 0;
`ifdef SRAM_ARB_RR_EN
      want = 4'b1010;
`else
      want = 4'b1111;
`endif
      do_reset();
      inst_bus.req = 1'b1; inst_bus.addr = 32'h1000_0004;
      data_bus.req = 1'b1; data_bus.addr = 32'h8000_0008;
      mem_bus.addr_ok = 1'b1; mem_bus.data_ok = 1'b1;
      for (int c = 0; c < 30 && g < 4; c++) begin
         @(negedge clk);
         #1;
         if (mem_bus.req) begin
            seq[3-g] = mem_bus.addr[31];
            g++;
         end
      end
      total++;
      if (g != 4) begin
         bad++; $display("FAIL arb_timeout grants=%0d want=4", g);
      end
      total++;
      if (seq !== want) begin
         bad++; $display("FAIL arb_order got=%b want=%b (1=data)", seq, want);
      end
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic test_full();
      int n;
      bit held;
      n    = 0;
      held = 1'b1;
      do_reset();
      data_bus.req = 1'b1; data_bus.addr = 32'h8000_0000; mem_bus.addr_ok = 1'b1;
      for (int c = 0; c < 20 && n < int'(Depth); c++) begin
         @(negedge clk);
         #1;
         if (mem_bus.req && mem_bus.addr_ok) n++;
      end
      total++;
      if (n != int'(Depth)) begin
         bad++; $display("FAIL full_fill accepts=%0d want=%0d", n, Depth);
      end
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         #1;
         if (mem_bus.req !== 1'b0) held = 1'b0;
      end
      total++;
      if (!held) begin
         bad++; $display("FAIL full_hold mem_req rose while full, want held 0");
      end
      @(negedge clk);
      mem_bus.data_ok = 1'b1;
      #1;
      total++;
      if ({mem_bus.req, data_bus.data_ok, inst_bus.data_ok} !== 3'b010) begin
         bad++;
         $display("FAIL full_pop got=%b%b%b want=010", mem_bus.req, data_bus.data_ok,
                  inst_bus.data_ok);
      end
      @(negedge clk);
      mem_bus.data_ok = 1'b0;
      #1;
      total++;
      if ({mem_bus.req, data_bus.addr_ok} !== 2'b11) begin
         bad++;
         $display("FAIL full_reassert got=%b%b want=11", mem_bus.req, data_bus.addr_ok);
      end
      held = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         #1;
         if (mem_bus.req !== 1'b0) held = 1'b0;
      end
      total++;
      if (!held) begin
         bad++; $display("FAIL full_refull mem_req rose with count back at depth");
      end
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic test_async_reset();
      int         n;
      logic [4:0] got;
      n = 0;
      do_reset();
      data_bus.req = 1'b1; data_bus.addr = 32'h8000_0010;
      inst_bus.req = 1'b1; inst_bus.addr = 32'h1000_0020;
      mem_bus.addr_ok = 1'b1;
      for (int c = 0; c < 12 && n < 2; c++) begin
         @(negedge clk);
         #1;
         if (mem_bus.req && mem_bus.addr_ok) n++;
      end
      total++;
      if (n != 2) begin
         bad++; $display("FAIL async_setup accepts=%0d want=2", n);
      end
      @(negedge clk);
      mem_bus.addr_ok = 1'b0;
      @(negedge clk);
      #1;
      total++;
      if (mem_bus.req !== 1'b1) begin
         bad++; $display("FAIL async_pre_grant got=%b want=1", mem_bus.req);
      end
      #1;
      resetn = 1'b0;
      #1;
      got = {mem_bus.req, inst_bus.addr_ok, data_bus.addr_ok, inst_bus.data_ok, data_bus.data_ok};
      total++;
      if (got !== 5'b0) begin
         bad++; $display("FAIL async_clear got=%b want=00000", got);
      end
      inst_bus.req = 1'b0; data_bus.req = 1'b0;
      #1;
      resetn = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'h5a5a_0000 + c;
         #1;
         total++;
         if ({inst_bus.data_ok, data_bus.data_ok} !== 2'b00) begin
            bad++;
            $display("FAIL async_stale_return c=%0d got=%b%b want=00", c, inst_bus.data_ok,
                     data_bus.data_ok);
         end
      end
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic test_random(input int cycles);
      bit          busy;
      bit          owner;
      bit          i_acc;
      bit          d_acc;
      bit          pop_now;
      bit          space;
      bit          exp_req;
      bit          acc;
      bit          head;
      bit          sb[$];
      int unsigned dok_pct;
      logic [70:0] want_attr;
      logic [70:0] got_attr;
`ifdef SRAM_ARB_RR_EN
      bit          last;
      last = 1'b0;
`endif
      busy = 1'b0; owner = 1'b0; i_acc = 1'b0; d_acc = 1'b0;
      do_reset();
      for (int c = 0; c < cycles; c++) begin
         dok_pct = ((c / 300) % 2 == 0) ? 70 : 8;
         // Masters hold their request until accepted, then may issue a fresh one.
         if (!inst_bus.req || i_acc) begin
            inst_bus.req   = ($urandom_range(0, 99) < 45);
            inst_bus.wr    = 1'($urandom);
            inst_bus.size  = 2'($urandom);
            inst_bus.wstrb = 4'($urandom);
            inst_bus.addr  = {4'h1, 28'($urandom)};
            inst_bus.wdata = $urandom;
         end
         if (!data_bus.req || d_acc) begin
            data_bus.req   = ($urandom_range(0, 99) < 55);
            data_bus.wr    = 1'($urandom);
            data_bus.size  = 2'($urandom);
            data_bus.wstrb = 4'($urandom);
            data_bus.addr  = {4'h8, 28'($urandom)};
            data_bus.wdata = $urandom;
         end
         mem_bus.addr_ok = ($urandom_range(0, 99) < 60);
         mem_bus.data_ok = ($urandom_range(0, 99) < dok_pct);
         mem_bus.rdata   = $urandom;
         #1;
         head    = (sb.size() > 0) ? sb[0] : 1'b0;
         pop_now = mem_bus.data_ok && (sb.size() > 0);
         space   = (sb.size() < int'(Depth)) || pop_now;
         exp_req = busy && space;
         acc     = exp_req && mem_bus.addr_ok;

         total++;
         if (mem_bus.req !== exp_req) begin
            bad++; $display("FAIL rnd_mem_req c=%0d got=%b want=%b", c, mem_bus.req, exp_req);
         end
         if (exp_req) begin
            got_attr  = {mem_bus.wr, mem_bus.size, mem_bus.wstrb, mem_bus.addr, mem_bus.wdata};
            want_attr = owner ?
               {data_bus.wr, data_bus.size, data_bus.wstrb, data_bus.addr, data_bus.wdata} :
               {inst_bus.wr, inst_bus.size, inst_bus.wstrb, inst_bus.addr, inst_bus.wdata};
            total++;
            if (got_attr !== want_attr) begin
               bad++; $display("FAIL rnd_attr c=%0d got=%h want=%h", c, got_attr, want_attr);
            end
         end
         total++;
         if ({inst_bus.addr_ok, data_bus.addr_ok} !== {acc && !owner, acc && owner}) begin
            bad++;
            $display("FAIL rnd_addr_ok c=%0d got=%b%b want=%b%b", c, inst_bus.addr_ok,
                     data_bus.addr_ok, acc && !owner, acc && owner);
         end
         total++;
         if ({inst_bus.data_ok, data_bus.data_ok} !== {pop_now && !head, pop_now && head}) begin
            bad++;
            $display("FAIL rnd_data_ok c=%0d got=%b%b want=%b%b", c, inst_bus.data_ok,
                     data_bus.data_ok, pop_now && !head, pop_now && head);
         end
         total++;
         if ({inst_bus.rdata, data_bus.rdata} !== {mem_bus.rdata, mem_bus.rdata}) begin
            bad++;
            $display("FAIL rnd_rdata c=%0d got=%h/%h want=%h", c, inst_bus.rdata, data_bus.rdata,
                     mem_bus.rdata);
         end

         i_acc = acc && !owner;
         d_acc = acc && owner;
         if (pop_now) void'(sb.pop_front());
         if (acc) begin
            sb.push_back(owner);
            busy = 1'b0;
`ifdef SRAM_ARB_RR_EN
            last = owner;
`endif
         end else if (!busy && space && (inst_bus.req || data_bus.req)) begin
            busy = 1'b1;
`ifdef SRAM_ARB_RR_EN
            owner = data_bus.req && (!inst_bus.req || !last);
`else
            owner = data_bus.req;
`endif
         end
         @(negedge clk);
      end
      idle_inputs();
   endtask

   initial begin
      total  = 0;
      bad    = 0;
      resetn = 1'b0;
      idle_inputs();
      test_reset();
      test_single_inst();
      test_both();
      test_arb();
      test_full();
      test_async_reset();
      test_random(4000);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
